// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
// The timeout feature is controlled by the ARB_TIMEOUT_EN macro (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int TO_CNT_W_DEF       = 8;

    // On a tie the port that did not win last time gets the grant.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        logic pick;
        pick = PORT_IF;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = PORT_LS;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit two-input multiplexer used for the arbiter's address and write-data paths.
module mux2x1_32bit (
    input  logic        sel_i,
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    output logic [31:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0) and load/store (port 1).
// Define ARB_TIMEOUT_EN to abort a BUSY transfer after TIMEOUT_CYCLES cycles without mem_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TO_CNT_W       = TO_CNT_W_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        sel,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    if (TIMEOUT_CYCLES >= (1 << TO_CNT_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1 .. 2**TO_CNT_W-1");
    end

    arb_state_e  state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;

`ifdef ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                to_q, to_d;
`endif

    mux2x1_32bit u_addr_mux (
        .sel_i (sel_q),
        .in0_i (addr0),
        .in1_i (addr1),
        .out_o (mem_addr)
    );

    mux2x1_32bit u_wdata_mux (
        .sel_i (sel_q),
        .in0_i (wdata0),
        .in1_i (wdata1),
        .out_o (mem_wdata)
    );

    assign mem_we = sel_q ? we1 : we0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    sel_d   = rr_pick(req0, req1, last_q);
                    last_d  = sel_d;
                    state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    if (!mem_we) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_ACK;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // Abort on the cycle that would make the stall count reach the limit.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TIMEOUT_CYCLES[TO_CNT_W-1:0]) begin
                        state_d = ST_ACK;
                        rdata_d = 32'h0;
                        to_d    = 1'b1;
                    end
`endif
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_req_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= PORT_IF;
            last_q    <= PORT_LS;
            rdata_q   <= 32'h0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            mem_req_q <= mem_req_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign err = to_q;
`else
    assign err = 1'b0;
`endif

    assign ack0        = (state_q == ST_ACK) && (sel_q == PORT_IF);
    assign ack1        = (state_q == ST_ACK) && (sel_q == PORT_LS);
    assign rdata       = rdata_q;
    assign mem_req     = mem_req_q;
    assign sel         = sel_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset, read, contention, write, req drop, timeout.
module tb_mem_port_arbiter;

    localparam int W = 33;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ack0, ack1, mem_req, mem_we, sel, err;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    logic [31:0]  model_rdata = '0;

    // Memory responder knobs
    bit          mem_auto = 1'b0;
    int          mem_delay = 0;
    int          busy_cnt = 0;
    logic [31:0] rd_key = '0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4), .TO_CNT_W(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .sel         (sel),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1, "watchdog");
    end

    // Memory model: answers mem_delay cycles after mem_req rises, data = address ^ rd_key.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_auto) begin
                if (mem_req) begin
                    if (busy_cnt >= mem_delay) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_addr ^ rd_key;
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = '0;
                    end
                    busy_cnt++;
                end else begin
                    busy_cnt  = 0;
                    mem_ready = 1'b0;
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    task automatic drive_step();
        @(posedge clock);
        #1;
    endtask

    task automatic await_ack(input int budget, output logic got_port, output logic [31:0] got_rdata,
                             output logic got_err, output logic got_both, output int busy_len,
                             output int waited, output bit ok);
        ok = 1'b0; busy_len = 0; waited = 0;
        got_port = 1'b0; got_rdata = '0; got_err = 1'b0; got_both = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            waited++;
            if (mem_req) busy_len++;
            if (ack0 || ack1) begin
                got_port  = ack1;
                got_rdata = rdata;
                got_err   = err;
                got_both  = ack0 && ack1;
                ok        = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int acks;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %0b want 0", mem_req); else n_pass++;
        n_checks++; if ({ack0, ack1} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); else n_pass++;
        n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel: got %0b want 0", sel); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
        drive_step();
        reset_n = 1'b1;
        mem_auto = 1'b0;
        mem_ready = 1'b0;
        drive_step();
        req1 = 1'b1; addr1 = 32'h0000_0100;
        repeat (2) @(negedge clock);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL reset_pre_busy: got %0b want 1", mem_req); else n_pass++;
        n_checks++; if (sel !== 1'b1) $display("FAIL reset_pre_sel: got %0b want 1", sel); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_async_mem_req: got %0b want 0", mem_req); else n_pass++;
        n_checks++; if (sel !== 1'b0) $display("FAIL reset_async_sel: got %0b want 0", sel); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_async_state: got %0d want 0", dbg_state); else n_pass++;
        n_checks++; if ({ack0, ack1, rdata} !== 34'h0) $display("FAIL reset_async_ack_rdata: got %b/%h want 00/0", {ack0, ack1}, rdata); else n_pass++;
        req1 = 1'b0;
        drive_step();
        reset_n = 1'b1;
        acks = 0;
        repeat (8) begin
            @(negedge clock);
            if (ack0 || ack1) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL reset_no_ack: got %0d acks want 0", acks); else n_pass++;
    endtask

    task automatic test_contention();
        logic p, b, e; logic [31:0] d; int bl, wt; bit ok;
        logic [W-1:0] exp;
        mem_auto = 1'b1; mem_delay = 0; rd_key = 32'h5A5A_0000;
        addr0 = 32'h0000_0100; addr1 = 32'h0000_0200; we0 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = i[0];
            exp_q.push_back({p, (p ? addr1 : addr0) ^ rd_key});
        end
        drive_step();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            await_ack(20, p, d, e, b, bl, wt, ok);
            if (i == 3) begin
                drive_step();
                req0 = 1'b0; req1 = 1'b0;
            end
            n_checks++;
            if (!ok || exp_q.size() == 0) begin
                $display("FAIL contention_ack%0d: got no ack/expectation want ack within 20 cycles", i);
            end else begin
                n_pass++;
                exp = exp_q.pop_front();
                model_rdata = exp[31:0];
                n_checks++; if (p !== exp[32]) $display("FAIL contention_port%0d: got %0b want %0b", i, p, exp[32]); else n_pass++;
                n_checks++; if (d !== exp[31:0]) $display("FAIL contention_rdata%0d: got %h want %h", i, d, exp[31:0]); else n_pass++;
                n_checks++; if (wt !== 3) $display("FAIL contention_spacing%0d: got %0d want 3", i, wt); else n_pass++;
                n_checks++; if (b !== 1'b0) $display("FAIL contention_both_ack%0d: got 1 want 0", i); else n_pass++;
            end
        end
    endtask

    task automatic test_read();
        logic p, b, e; logic [31:0] d; int bl, wt; bit ok;
        logic [W-1:0] exp;
        mem_auto = 1'b1; mem_delay = 2; rd_key = 32'hCAFE_0041;
        exp_q.push_back({1'b0, 32'hCAFE_0001});
        drive_step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0040;
        @(negedge clock);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL read_latency_idle: got %0b want 0", mem_req); else n_pass++;
        @(negedge clock);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL read_latency_busy: got %0b want 1", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0000_0040) $display("FAIL read_mem_addr: got %h want 00000040", mem_addr); else n_pass++;
        await_ack(20, p, d, e, b, bl, wt, ok);
        drive_step();
        req0 = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL read_ack: got none want ack0 within 20 cycles");
        end else begin
            n_pass++;
            exp = exp_q.pop_front();
            model_rdata = exp[31:0];
            n_checks++; if (p !== exp[32] || b !== 1'b0) $display("FAIL read_port: got port %0b both %0b want port 0 both 0", p, b); else n_pass++;
            n_checks++; if (d !== exp[31:0]) $display("FAIL read_rdata: got %h want %h", d, exp[31:0]); else n_pass++;
            n_checks++; if (bl !== 2) $display("FAIL read_busy_len: got %0d want 2", bl); else n_pass++;
        end
    endtask

    task automatic test_write();
        logic p, b, e; logic [31:0] d; int bl, wt; bit ok;
        logic [W-1:0] exp;
        mem_auto = 1'b1; mem_delay = 1; rd_key = 32'hFFFF_0000;
        exp_q.push_back({1'b1, model_rdata});
        drive_step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0080; wdata1 = 32'h1234_5678;
        repeat (2) @(negedge clock);
        n_checks++; if (mem_we !== 1'b1) $display("FAIL write_mem_we: got %0b want 1", mem_we); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h1234_5678) $display("FAIL write_mem_wdata: got %h want 12345678", mem_wdata); else n_pass++;
        n_checks++; if (sel !== 1'b1) $display("FAIL write_sel: got %0b want 1", sel); else n_pass++;
        await_ack(20, p, d, e, b, bl, wt, ok);
        drive_step();
        req1 = 1'b0; we1 = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL write_ack: got none want ack1 within 20 cycles");
        end else begin
            n_pass++;
            exp = exp_q.pop_front();
            n_checks++; if (p !== exp[32] || b !== 1'b0) $display("FAIL write_port: got port %0b both %0b want port 1 both 0", p, b); else n_pass++;
            n_checks++; if (d !== exp[31:0]) $display("FAIL write_rdata_kept: got %h want %h", d, exp[31:0]); else n_pass++;
        end
    endtask

    task automatic test_req_drop();
        logic p, b, e; logic [31:0] d; int bl, wt; bit ok;
        logic [W-1:0] exp;
        int acks;
        mem_auto = 1'b1; mem_delay = 2; rd_key = 32'h0BAD_0000;
        exp_q.push_back({1'b0, 32'h0000_0044 ^ rd_key});
        drive_step();
        req0 = 1'b1; addr0 = 32'h0000_0044;
        repeat (2) @(negedge clock);
        drive_step();
        req0 = 1'b0;
        await_ack(20, p, d, e, b, bl, wt, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL drop_ack: got none want ack0 within 20 cycles");
        end else begin
            n_pass++;
            exp = exp_q.pop_front();
            model_rdata = exp[31:0];
            n_checks++; if (p !== exp[32]) $display("FAIL drop_port: got %0b want %0b", p, exp[32]); else n_pass++;
            n_checks++; if (d !== exp[31:0]) $display("FAIL drop_rdata: got %h want %h", d, exp[31:0]); else n_pass++;
        end
        mem_auto = 1'b0;
        mem_ready = 1'b0;
        repeat (2) drive_step();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        drive_step();
        mem_ready = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clock);
            if (ack0 || ack1 || mem_req) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL idle_ready_activity: got %0d active cycles want 0", acks); else n_pass++;
        n_checks++; if (rdata !== model_rdata) $display("FAIL idle_ready_rdata: got %h want %h", rdata, model_rdata); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL idle_ready_state: got %0d want 0", dbg_state); else n_pass++;
    endtask

    task automatic test_timeout();
        mem_auto = 1'b0;
        mem_ready = 1'b0;
        drive_step();
        req0 = 1'b1; addr0 = 32'h0000_0048;
`ifdef ARB_TIMEOUT_EN
        begin
            logic p, b, e; logic [31:0] d; int bl, wt; bit ok;
            logic [W-1:0] exp;
            exp_q.push_back({1'b0, 32'h0});
            await_ack(20, p, d, e, b, bl, wt, ok);
            drive_step();
            req0 = 1'b0;
            n_checks++;
            if (!ok) begin
                $display("FAIL timeout_ack: got none want ack0 within 20 cycles");
            end else begin
                n_pass++;
                exp = exp_q.pop_front();
                n_checks++; if (p !== exp[32] || b !== 1'b0) $display("FAIL timeout_port: got port %0b both %0b want port 0 both 0", p, b); else n_pass++;
                n_checks++; if (d !== exp[31:0]) $display("FAIL timeout_rdata: got %h want %h", d, exp[31:0]); else n_pass++;
                n_checks++; if (e !== 1'b1) $display("FAIL timeout_err: got %0b want 1", e); else n_pass++;
                n_checks++; if (bl !== 4) $display("FAIL timeout_busy_len: got %0d want 4", bl); else n_pass++;
            end
            @(negedge clock);
            n_checks++; if (err !== 1'b0) $display("FAIL timeout_err_pulse: got %0b want 0", err); else n_pass++;
        end
`else
        begin
            int errs, acks;
            errs = 0; acks = 0;
            repeat (20) begin
                @(negedge clock);
                if (err) errs++;
                if (ack0 || ack1) acks++;
            end
            n_checks++; if (dbg_state !== 2'd1) $display("FAIL no_timeout_state: got %0d want 1", dbg_state); else n_pass++;
            n_checks++; if (mem_req !== 1'b1) $display("FAIL no_timeout_mem_req: got %0b want 1", mem_req); else n_pass++;
            n_checks++; if (errs !== 0) $display("FAIL no_timeout_err: got %0d err cycles want 0", errs); else n_pass++;
            n_checks++; if (acks !== 0) $display("FAIL no_timeout_ack: got %0d acks want 0", acks); else n_pass++;
            req0 = 1'b0;
            reset_n = 1'b0;
            drive_step();
            reset_n = 1'b1;
        end
`endif
        n_checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_read();
        test_write();
        test_req_drop();
        test_timeout();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
